// File: rtl/multicycle_ctrl_hs.sv
// Multicycle RV32I-subset control unit with a variable-latency memory handshake.
// Sequences fetch/decode/execute/memory/writeback states, decodes ALUControl and
// ImmSrc, and raises a sticky fault on an illegal opcode or a memory-wait timeout.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5     instruction fields from the instruction register
//   Zero                     ALU zero flag (branch resolution)
//   MemReady                 memory finished the current access this cycle
//   MemReq                   memory access requested, held until MemReady
//   ImmSrc                   immediate format select
//   ALUSrcA/ALUSrcB          ALU operand selects
//   ResultSrc, AdrSrc        result bus and memory address selects
//   ALUControl               ALU operation
//   IRWrite/PCWrite/RegWrite/MemWrite  datapath write enables
//   Fault, FaultCode         sticky fault flag and cause
//   InstRet                  retired-instruction count
//
// Optional feature: define MULTICYCLE_INSTRET_EN to build the InstRet counter;
// otherwise InstRet is tied to zero.
module multicycle_ctrl_hs #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic                 AdrSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 Fault,
    output logic [1:0]           FaultCode,
    output logic [31:0]          InstRet
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Count value on the last tolerated non-ready cycle: 2**TIMEOUT_W-2, so the
    // (2**TIMEOUT_W-1)-th consecutive non-ready cycle triggers the fault.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = ~TIMEOUT_W'(1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_JALRADR, S_JAL, S_BRANCH, S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [1:0]           code_d;
    logic [1:0]           alu_op;
    logic [2:0]           alu_c;
    logic                 waiting;

    // State, wait counter and fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            Fault     <= 1'b0;
            FaultCode <= 2'b00;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            Fault     <= (state_d == S_FAULT);
            FaultCode <= code_d;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        state_d   = state_q;
        code_d    = FaultCode;
        wait_d    = '0;
        waiting   = 1'b0;
        alu_op    = 2'b00;
        MemReq    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                waiting   = 1'b1;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALRADR;
                    OP_BR:        state_d = S_BRANCH;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                waiting = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                waiting  = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JAL;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = Zero ^ funct3[0];  // beq taken on Zero, bne on !Zero
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
        // Wait-state timeout; a MemReady in the final cycle wins
        if (waiting && !MemReady) begin
            if (wait_q == WAIT_LAST) begin
                state_d = S_FAULT;
                code_d  = (state_q == S_FETCH) ? 2'b10 : 2'b11;
            end else begin
                wait_d = wait_q + TIMEOUT_W'(1);
            end
        end
    end

    // ALU operation decode
    always_comb begin
        alu_c = 3'b000;
        case (alu_op)
            2'b01: alu_c = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_c = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b001:  alu_c = 3'b110;
                    3'b010:  alu_c = 3'b101;
                    3'b100:  alu_c = 3'b100;
                    3'b101:  alu_c = 3'b111;
                    3'b110:  alu_c = 3'b011;
                    3'b111:  alu_c = 3'b010;
                    default: alu_c = 3'b000;
                endcase
            end
            default: alu_c = 3'b000;
        endcase
        ALUControl = ALUCTRL_W'(alu_c);
    end

    // Immediate format from opcode only
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    // An instruction retires when its final state hands control back to FETCH
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BRANCH));

    always_ff @(posedge clk) begin
        if (reset)       instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign InstRet = instret_q;
`else
    assign InstRet = '0;
`endif

endmodule
